// File: rtl/bf_exec_unit.sv
// Multi-thread execute stage: per-thread data pointers, tape ALU ops, forward/backward
// branches and blocking OUT/IN, with a single EX slot fed from a registered issue stage.
module bf_exec_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NTHREADS = 4,
  parameter int TID_W    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [TID_W-1:0]  issue_tid,
  input  logic [15:0]       ins_in,
  output logic [ADDR_W-1:0] ptr_select,
  input  logic [DATA_W-1:0] val_in,
  output logic              wb_en,
  output logic [ADDR_W-1:0] ptr_wb,
  output logic [DATA_W-1:0] val_out,
  output logic              branch_en,
  output logic [TID_W-1:0]  branch_tid,
  output logic [15:0]       branch_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data
);

  localparam logic [3:0] OP_PLUS  = 4'd1;
  localparam logic [3:0] OP_MINUS = 4'd2;
  localparam logic [3:0] OP_INC   = 4'd3;
  localparam logic [3:0] OP_DEC   = 4'd4;
  localparam logic [3:0] OP_BRZ   = 4'd5;
  localparam logic [3:0] OP_BRNZ  = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_IN    = 4'd8;

  typedef enum logic {EX_EMPTY, EX_BUSY} ex_state_t;

  ex_state_t         state_q, state_d;
  logic [15:0]       ex_ins;
  logic [TID_W-1:0]  ex_tid;
  logic [ADDR_W-1:0] ex_ptr;
  logic [DATA_W-1:0] ex_val;
  logic [ADDR_W-1:0] ptr_q [NTHREADS];

  logic [3:0]        ex_op;
  logic              ex_valid, ex_done, accept, is_wb, is_incdec;
  logic [ADDR_W-1:0] ptr_next;
  logic [DATA_W-1:0] fwd_val;

  assign ex_op     = ex_ins[15:12];
  assign ex_valid  = (state_q == EX_BUSY);
  assign is_wb     = (ex_op == OP_PLUS) || (ex_op == OP_MINUS) || (ex_op == OP_IN);
  assign is_incdec = (ex_op == OP_INC) || (ex_op == OP_DEC);
  assign ptr_next  = (ex_op == OP_INC) ? ex_ptr + 1'b1 : ex_ptr - 1'b1;

  // Only blocked I/O keeps the slot; everything else retires in its first EX cycle.
  assign ex_done = ex_valid && !((ex_op == OP_OUT) && !out_ready)
                            && !((ex_op == OP_IN) && !in_valid);
  assign issue_ready = !ex_valid || ex_done;
  assign accept      = issue_valid && issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EX_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)       state_d = EX_BUSY;
    else if (ex_done) state_d = EX_EMPTY;
  end

  always_comb begin
    wb_en      = 1'b0;
    ptr_wb     = '0;
    val_out    = DATA_W'(16'hdead);
    branch_en  = 1'b0;
    branch_tid = '0;
    branch_val = 16'hdead;
    out_valid  = 1'b0;
    out_data   = '0;
    in_ready   = 1'b0;
    if (ex_valid) begin
      ptr_wb = ex_ptr;
      wb_en  = ex_done && is_wb;
      case (ex_op)
        OP_PLUS:  val_out = ex_val + 1'b1;
        OP_MINUS: val_out = ex_val - 1'b1;
        OP_IN: begin
          in_ready = 1'b1;
          val_out  = in_data;
        end
        OP_OUT: begin
          out_valid = 1'b1;
          out_data  = ex_val;
        end
        OP_BRZ:  branch_en = (ex_val == '0);
        OP_BRNZ: branch_en = (ex_val != '0);
        default: ;
      endcase
      if (branch_en) begin
        branch_tid = ex_tid;
        branch_val = {4'b0, ex_ins[11:0]};
      end
    end
  end

  // Same-thread forwarding so back-to-back instructions never see a stale pointer or cell.
  always_comb begin
    ptr_select = ptr_q[issue_tid];
    if (ex_done && is_incdec && (ex_tid == issue_tid))
      ptr_select = ptr_next;
    fwd_val = val_in;
    if (wb_en && (ex_tid == issue_tid) && (ex_ptr == ptr_select))
      fwd_val = val_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ins <= '0;
      ex_tid <= '0;
      ex_ptr <= '0;
      ex_val <= '0;
      for (int t = 0; t < NTHREADS; t++) ptr_q[t] <= '0;
    end else begin
      if (ex_done && is_incdec)
        ptr_q[ex_tid] <= ptr_next;
      if (accept) begin
        ex_ins <= ins_in;
        ex_tid <= issue_tid;
        ex_ptr <= ptr_select;
        ex_val <= fwd_val;
      end
    end
  end

endmodule

// File: tb/tb_bf_exec_unit.sv
// Directed bench for bf_exec_unit: a tape memory model, a queue of expected
// writeback/branch/OUT events, and a negedge monitor that checks each event as it fires.
module tb_bf_exec_unit;

  localparam logic [3:0] OP_PLUS  = 4'd1;
  localparam logic [3:0] OP_INC   = 4'd3;
  localparam logic [3:0] OP_DEC   = 4'd4;
  localparam logic [3:0] OP_BRZ   = 4'd5;
  localparam logic [3:0] OP_BRNZ  = 4'd6;
  localparam logic [3:0] OP_OUT   = 4'd7;
  localparam logic [3:0] OP_IN    = 4'd8;

  localparam int EV_WB  = 0;
  localparam int EV_BR  = 1;
  localparam int EV_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_tid;
  logic [15:0] ins_in;
  logic [15:0] ptr_select, val_in;
  logic        wb_en;
  logic [15:0] ptr_wb, val_out;
  logic        branch_en;
  logic [1:0]  branch_tid;
  logic [15:0] branch_val;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        in_valid, in_ready;
  logic [15:0] in_data;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp_e;
  int  act_kind;
  logic [15:0] act_a, act_b;
  int  n_cmp = 0;
  int  n_err = 0;

  logic [15:0] tape [256];

  bf_exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_tid   (issue_tid),
    .ins_in      (ins_in),
    .ptr_select  (ptr_select),
    .val_in      (val_in),
    .wb_en       (wb_en),
    .ptr_wb      (ptr_wb),
    .val_out     (val_out),
    .branch_en   (branch_en),
    .branch_tid  (branch_tid),
    .branch_val  (branch_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data)
  );

  always #5 clk = ~clk;

  // Tape model: async read, write on the clock edge; cell 2 preloaded with 0x2A for OUT.
  assign val_in = tape[ptr_select[7:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) tape[i] <= 16'h0;
      tape[2] <= 16'h002A;
    end else if (wb_en) begin
      tape[ptr_wb[7:0]] <= val_out;
    end
  end

  // Monitor: every writeback, branch or OUT handoff must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && (wb_en || branch_en || (out_valid && out_ready))) begin
      if (wb_en) begin
        act_kind = EV_WB;  act_a = ptr_wb;            act_b = val_out;
      end else if (branch_en) begin
        act_kind = EV_BR;  act_a = {14'b0, branch_tid}; act_b = branch_val;
      end else begin
        act_kind = EV_OUT; act_a = 16'h0;             act_b = out_data;
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL unexpected_event: got kind=%0d a=%h b=%h, required none", act_kind, act_a, act_b);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e.kind != act_kind || exp_e.a != act_a || exp_e.b != act_b) begin
          n_err++;
          $display("[TB] FAIL event: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                   act_kind, act_a, act_b, exp_e.kind, exp_e.a, exp_e.b);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic expectEvent(input int kind, input logic [15:0] a, input logic [15:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] tid, input logic [3:0] op, input logic [11:0] tgt);
    issue_valid = 1'b1;
    issue_tid   = tid;
    ins_in      = {op, tgt};
    advance();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_tid   = 2'd0;
    ins_in      = 16'h0;
    out_ready   = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'h0;

    #2;
    checkOutput("rst_wb_en",      wb_en,      0);
    checkOutput("rst_branch_en",  branch_en,  0);
    checkOutput("rst_out_valid",  out_valid,  0);
    checkOutput("rst_in_ready",   in_ready,   0);
    checkOutput("rst_val_out",    val_out,    16'hdead);
    checkOutput("rst_branch_val", branch_val, 16'hdead);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_issue_ready", issue_ready, 1);
    checkOutput("rst_ptr_select",  ptr_select,  0);

    // tid0 PLUS x3 on cell 0: the 2nd and 3rd rely on value forwarding
    for (int i = 1; i <= 3; i++) expectEvent(EV_WB, 16'h0000, 16'(i));
    for (int i = 0; i < 3; i++) applyStimulus(2'd0, OP_PLUS, 12'h0);
    advance();

    // tid1 DEC wraps to FFFF; tid0 untouched
    applyStimulus(2'd1, OP_DEC, 12'h0);
    checkOutput("dec_fwd_ptr", ptr_select, 16'hFFFF);
    advance();
    checkOutput("dec_reg_ptr", ptr_select, 16'hFFFF);
    issue_tid = 2'd0; #1;
    checkOutput("tid0_ptr_kept", ptr_select, 16'h0000);

    // tid2 INC then PLUS back-to-back: forwarded pointer in the issue cycle
    applyStimulus(2'd2, OP_INC, 12'h0);
    issue_valid = 1'b1; issue_tid = 2'd2; ins_in = {OP_PLUS, 12'h0}; #1;
    checkOutput("inc_fwd_ptr", ptr_select, 16'h0001);
    expectEvent(EV_WB, 16'h0001, 16'h0001);
    advance();
    advance();

    // Branches on tid3 at cell FFFF: BRZ taken at 0, then cell=5 for BRNZ taken / BRZ not taken
    applyStimulus(2'd3, OP_DEC, 12'h0);
    expectEvent(EV_BR, 16'h0003, 16'h0123);
    applyStimulus(2'd3, OP_BRZ, 12'h123);
    for (int i = 1; i <= 5; i++) begin
      expectEvent(EV_WB, 16'hFFFF, 16'(i));
      applyStimulus(2'd3, OP_PLUS, 12'h0);
    end
    expectEvent(EV_BR, 16'h0003, 16'h0456);
    applyStimulus(2'd3, OP_BRNZ, 12'h456);
    applyStimulus(2'd3, OP_BRZ, 12'h789);
    checkOutput("brz_not_taken", branch_en, 0);
    advance();

    // OUT of 0x2A with a 3-cycle consumer stall
    applyStimulus(2'd0, OP_INC, 12'h0);
    applyStimulus(2'd0, OP_INC, 12'h0);
    expectEvent(EV_OUT, 16'h0000, 16'h002A);
    applyStimulus(2'd0, OP_OUT, 12'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("out_stall_valid", out_valid,   1);
      checkOutput("out_stall_data",  out_data,    16'h002A);
      checkOutput("out_stall_ready", issue_ready, 0);
      advance();
    end
    out_ready = 1'b1; #1;
    checkOutput("out_retire_ready", issue_ready, 1);
    advance();
    out_ready = 1'b0; #1;
    checkOutput("out_done_valid", out_valid, 0);

    // IN with a 2-cycle producer wait, then one writeback of 0x55 to cell 2
    applyStimulus(2'd0, OP_IN, 12'h0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("in_wait_ready", in_ready, 1);
      checkOutput("in_wait_wb",    wb_en,    0);
      advance();
    end
    in_data = 16'h0055; in_valid = 1'b1;
    expectEvent(EV_WB, 16'h0002, 16'h0055);
    #1;
    checkOutput("in_retire_ready", issue_ready, 1);
    advance();
    in_valid = 1'b0; #1;
    checkOutput("in_done_ready", in_ready, 0);

    // Reset while IN is stalled: discarded, no writeback, all pointers back to 0
    applyStimulus(2'd1, OP_IN, 12'h0);
    checkOutput("in_stall_ready", in_ready, 1);
    rst_n = 1'b0; #1;
    checkOutput("rst_async_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 16'h0077; #1;
    checkOutput("rst_no_wb", wb_en, 0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_issue_ready", issue_ready, 1);
    for (int t = 0; t < 4; t++) begin
      issue_tid = 2'(t); #1;
      checkOutput("post_rst_ptr", ptr_select, 16'h0000);
    end

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
